coh_acc16: RTL and testbench
============================

# coh_acc16

Coherent accumulator directly upstream of the 16-bit-to-10bit+exp complex compressor in the acquire engine. Sums a programmable number of signed complex correlator samples, scales the sum by a programmable right shift and saturates it to 16-bit I/Q. It then presents one registered 16-bit complex result per accumulation window, in exactly the format the compressor consumes.

## Interface
- IN_WIDTH, 12, signed width of input I and Q samples
- ACC_WIDTH, 20, internal accumulator width; must be at least IN_WIDTH+7
- clk  input  1  clock; all logic on rising edge
- rst_b  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; arms a new window (honoured only in IDLE)
- abort  input  1  synchronous cancel; returns to IDLE, no output
- cont  input  1  continuous mode; sampled at window end
- acc_len  input  7  samples per window, 1..127; value 0 is treated as 1
- shift  input  3  right shift applied to the sum, 0..4; values 5..7 are treated as 4
- in_valid  input  1  sample strobe
- in_i, in_q  input  IN_WIDTH  signed sample
- out_valid  output  1  one-cycle result strobe
- out_i, out_q  output  16  signed scaled, saturated sum
- busy  output  1  high in ACC state
- sat_flag  output  1  sticky: some result in the current run saturated

## Operation
- States: IDLE, ACC.
- IDLE, start=1:
  - Latch acc_len to len_r and shift to shift_r.
  - Clear acc_i, acc_q and the sample counter cnt.
  - Clear sat_flag.
  - Go to ACC.
- In IDLE, in_valid is ignored.
- ACC, in_valid=1, cnt < len_r-1: acc += sign-extended sample; cnt++.
- ACC, in_valid=1, cnt == len_r-1 (last sample):
  - final = acc + sample.
  - If shift_r > 0, add 2^(shift_r-1) (only with the rounding macro; see Configuration).
  - Arithmetic right shift by shift_r.
  - Clip to [-32768, 32767]; set sat_flag if either I or Q clipped.
  - Register the result into out_i/out_q and pulse out_valid.
  - If cont=1: stay in ACC with cnt=0 and acc=0; len_r and shift_r are retained. Otherwise go to IDLE.
- ACC with in_valid=0: hold all state.
- start during ACC: ignored.
- abort (any state):
  - Next state IDLE; acc and cnt cleared.
  - out_valid is not asserted that cycle, even if the current cycle carried the last sample. abort wins.
  - sat_flag is held.
- Sum of 127 full-scale samples needs IN_WIDTH+7 bits. The accumulator never wraps; saturation is applied only at the output.
- Arithmetic is two's complement throughout. The shift is arithmetic, so a negative sum floors toward minus infinity without rounding.

## Timing
- Reset values:
  - out_valid = 0, out_i = 0, out_q = 0.
  - busy = 0, sat_flag = 0.
  - State IDLE; acc, cnt, len_r and shift_r all 0.
- start at cycle T: busy=1 from T+1. A sample with in_valid at T+1 is the first one accumulated.
- Latency: last sample accepted at cycle T gives out_valid=1 and valid data at T+1, for exactly one cycle.
- out_i/out_q hold their value until the next result; they are not cleared by start or abort.
- Continuous mode: a sample at T+1 (the cycle after the last sample) belongs to the new window, so no sample is lost. With in_valid held high, out_valid pulses exactly every len_r cycles.
- Non-continuous mode: busy=0 from T+1. A new start is accepted at T+1.
- acc_len and shift may change freely; only values latched at start matter.
- No backpressure: the downstream compressor is combinational and always accepts.

## Configuration
- COH_ACC_ROUND_EN defined: add 2^(shift_r-1) to the sum before the shift (round half up). Nothing is added when shift_r=0.
- COH_ACC_ROUND_EN undefined: plain arithmetic shift (truncate toward minus infinity), with no adder in the rounding path.
- Saturation and sat_flag behave identically in both builds.

## Test plan
- acc_len=4, shift=0, in_i=100, in_q=-50 on 4 consecutive cycles -> one out_valid; out_i=400, out_q=-200, sat_flag=0, busy falls the same cycle.
- acc_len=127, shift=0, in_i=2047, in_q=-2048 every cycle -> out_i=32767, out_q=-32768, sat_flag=1. The flag stays 1 until the next start.
- acc_len=3, shift=2, in_i=1 -> out_i=1 with COH_ACC_ROUND_EN, out_i=0 without. With in_i=-1 -> out_i=-1 in both builds.
- cont=1, acc_len=5, in_valid continuous for 20 cycles, in_i = cycle index 0..19 -> four out_valid pulses 5 cycles apart, out_i = 10, 35, 60, 85.
- acc_len=8, in_valid gaps (every other cycle), abort asserted on the same cycle as the 8th sample -> no out_valid, busy=0 next cycle. The following start with acc_len=2, in_i=7 gives out_i=14.
- rst_b driven low mid-window after 3 of 6 samples -> all outputs 0 immediately. After release, samples without start produce no output.

Source files
------------

// File: rtl/coh_acc16.sv
// coh_acc16 - coherent complex accumulator feeding the 16-bit complex compressor.
//
// Sums acc_len signed complex samples (0 treated as 1). The sum is arithmetically
// right-shifted by shift (values above 4 are treated as 4) and saturated to 16-bit
// I/Q. One registered result is emitted per window, with a single-cycle out_valid.
//
// Optional feature macro: COH_ACC_ROUND_EN
//   defined   : add 2^(shift_r-1) before the shift (round half up)
//   undefined : plain arithmetic shift (floor), no rounding adder
//
// Handshake: in_valid is a one-sided strobe with no ready. Every in_valid cycle
// in ACC consumes one sample. out_valid is a one-cycle strobe with no backpressure.
//
// Ports:
//   clk, rst_b          clock (rising edge), asynchronous active-low reset
//   start               arms a new window (IDLE only); latches acc_len/shift
//   abort               synchronous cancel, back to IDLE with no output
//   cont                continuous mode, sampled on the last sample of a window
//   acc_len[6:0]        samples per window
//   shift[2:0]          right shift applied to the window sum
//   in_valid, in_i/q    sample strobe and signed IN_WIDTH samples
//   out_valid, out_i/q  result strobe and saturated 16-bit result (held)
//   busy                high while in ACC
//   sat_flag            sticky saturation indicator, cleared by start
//   fsm_state           debug view of the FSM state (0 = IDLE, 1 = ACC)
module coh_acc16 #(
  parameter int IN_WIDTH  = 12,
  parameter int ACC_WIDTH = 20
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       cont,
  input  logic [6:0]                 acc_len,
  input  logic [2:0]                 shift,
  input  logic                       in_valid,
  input  logic signed [IN_WIDTH-1:0] in_i,
  input  logic signed [IN_WIDTH-1:0] in_q,
  output logic                       out_valid,
  output logic signed [15:0]         out_i,
  output logic signed [15:0]         out_q,
  output logic                       busy,
  output logic                       sat_flag,
  output logic [0:0]                 fsm_state
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ACC  = 1'b1;

  // Comparison width: wide enough to hold both the shifted sum and the 16-bit limits.
  localparam int EW = (ACC_WIDTH > 17) ? ACC_WIDTH : 17;
  localparam logic signed [EW-1:0] MAX16 = EW'(32767);
  localparam logic signed [EW-1:0] MIN16 = EW'(-32768);

  logic [0:0]                  state;
  logic [6:0]                  cnt;
  logic [6:0]                  len_r;
  logic [2:0]                  shift_r;
  logic signed [ACC_WIDTH-1:0] acc_i;
  logic signed [ACC_WIDTH-1:0] acc_q;

  logic [6:0]                  len_eff;
  logic [2:0]                  shift_eff;
  logic                        is_last;
  logic signed [ACC_WIDTH-1:0] sum_i;
  logic signed [ACC_WIDTH-1:0] sum_q;
  logic signed [ACC_WIDTH-1:0] pre_i;
  logic signed [ACC_WIDTH-1:0] pre_q;
  logic signed [ACC_WIDTH-1:0] shf_i;
  logic signed [ACC_WIDTH-1:0] shf_q;
  logic signed [EW-1:0]        ext_i;
  logic signed [EW-1:0]        ext_q;
  logic                        sat_hi_i;
  logic                        sat_lo_i;
  logic                        sat_hi_q;
  logic                        sat_lo_q;
  logic signed [15:0]          res_i;
  logic signed [15:0]          res_q;

  assign len_eff   = (acc_len == 7'd0) ? 7'd1 : acc_len;
  assign shift_eff = (shift > 3'd4) ? 3'd4 : shift;
  assign is_last   = (cnt == (len_r - 7'd1));

  // Window sum including the current sample; used both to accumulate and to finalise.
  assign sum_i = acc_i + {{(ACC_WIDTH-IN_WIDTH){in_i[IN_WIDTH-1]}}, in_i};
  assign sum_q = acc_q + {{(ACC_WIDTH-IN_WIDTH){in_q[IN_WIDTH-1]}}, in_q};

`ifdef COH_ACC_ROUND_EN
  // Half an LSB of the shifted result; zero when no shift is applied.
  logic signed [ACC_WIDTH-1:0] rnd;
  assign rnd   = (shift_r == 3'd0) ? '0 : (ACC_WIDTH'(1) << (shift_r - 3'd1));
  assign pre_i = sum_i + rnd;
  assign pre_q = sum_q + rnd;
`else
  assign pre_i = sum_i;
  assign pre_q = sum_q;
`endif

  // Arithmetic shift: negative sums floor toward minus infinity.
  assign shf_i = pre_i >>> shift_r;
  assign shf_q = pre_q >>> shift_r;
  assign ext_i = EW'(shf_i);
  assign ext_q = EW'(shf_q);

  assign sat_hi_i = (ext_i > MAX16);
  assign sat_lo_i = (ext_i < MIN16);
  assign sat_hi_q = (ext_q > MAX16);
  assign sat_lo_q = (ext_q < MIN16);

  assign res_i = sat_hi_i ? 16'sh7fff : (sat_lo_i ? 16'sh8000 : ext_i[15:0]);
  assign res_q = sat_hi_q ? 16'sh7fff : (sat_lo_q ? 16'sh8000 : ext_q[15:0]);

  assign busy      = (state == S_ACC);
  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= S_IDLE;
      cnt       <= '0;
      len_r     <= '0;
      shift_r   <= '0;
      acc_i     <= '0;
      acc_q     <= '0;
      out_valid <= 1'b0;
      out_i     <= '0;
      out_q     <= '0;
      sat_flag  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (abort) begin
        // Abort beats a coincident last sample: no result, sat_flag untouched.
        state <= S_IDLE;
        acc_i <= '0;
        acc_q <= '0;
        cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              len_r    <= len_eff;
              shift_r  <= shift_eff;
              acc_i    <= '0;
              acc_q    <= '0;
              cnt      <= '0;
              sat_flag <= 1'b0;
              state    <= S_ACC;
            end
          end
          S_ACC: begin
            if (in_valid) begin
              if (is_last) begin
                out_valid <= 1'b1;
                out_i     <= res_i;
                out_q     <= res_q;
                if (sat_hi_i || sat_lo_i || sat_hi_q || sat_lo_q) sat_flag <= 1'b1;
                acc_i <= '0;
                acc_q <= '0;
                cnt   <= '0;
                if (!cont) state <= S_IDLE;
              end else begin
                acc_i <= sum_i;
                acc_q <= sum_q;
                cnt   <= cnt + 7'd1;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_coh_acc16.sv
// tb_coh_acc16 - directed, table-driven bench for coh_acc16.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_coh_acc16;

  logic               clk;
  logic               rst_b;
  logic               start;
  logic               abort;
  logic               cont;
  logic [6:0]         acc_len;
  logic [2:0]         shift;
  logic               in_valid;
  logic signed [11:0] in_i;
  logic signed [11:0] in_q;
  logic               out_valid;
  logic signed [15:0] out_i;
  logic signed [15:0] out_q;
  logic               busy;
  logic               sat_flag;
  logic [0:0]         fsm_state;

  int n_chk  = 0;
  int n_pass = 0;

  coh_acc16 #(.IN_WIDTH(12), .ACC_WIDTH(20)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .start     (start),
    .abort     (abort),
    .cont      (cont),
    .acc_len   (acc_len),
    .shift     (shift),
    .in_valid  (in_valid),
    .in_i      (in_i),
    .in_q      (in_q),
    .out_valid (out_valid),
    .out_i     (out_i),
    .out_q     (out_q),
    .busy      (busy),
    .sat_flag  (sat_flag),
    .fsm_state (fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int len;  // acc_len applied at start
    int sh;   // shift applied at start
    int n;    // samples actually in the window
    int i;
    int q;
    int ei;
    int eq;
    int es;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // One non-continuous window with a constant sample value.
  task automatic run_window(input int tag, input vec_t v);
    int early;
    @(negedge clk);
    start   = 1'b1;
    acc_len = 7'(v.len);
    shift   = 3'(v.sh);
    cont    = 1'b0;
    @(negedge clk);
    start   = 1'b0;
    acc_len = 7'd99;  // only the latched value may matter
    shift   = 3'd0;
    chk($sformatf("v%0d_busy_after_start", tag), int'(busy), 1);
    chk($sformatf("v%0d_sat_cleared", tag), int'(sat_flag), 0);
    early = 0;
    for (int k = 0; k < v.n; k++) begin
      in_valid = 1'b1;
      in_i     = 12'(v.i);
      in_q     = 12'(v.q);
      @(negedge clk);
      if (k < v.n - 1 && out_valid) early++;
    end
    in_valid = 1'b0;
    chk($sformatf("v%0d_early_valid", tag), early, 0);
    chk($sformatf("v%0d_out_valid", tag), int'(out_valid), 1);
    chk($sformatf("v%0d_out_i", tag), int'($signed(out_i)), v.ei);
    chk($sformatf("v%0d_out_q", tag), int'($signed(out_q)), v.eq);
    chk($sformatf("v%0d_sat_flag", tag), int'(sat_flag), v.es);
    chk($sformatf("v%0d_busy_fall", tag), int'(busy), 0);
    @(negedge clk);
    chk($sformatf("v%0d_valid_one_cycle", tag), int'(out_valid), 0);
    chk($sformatf("v%0d_sat_held", tag), int'(sat_flag), v.es);
  endtask

  initial begin
    int pulses;
    int ov_seen;
    int exp_c[4];
    vec_t v2;

    //                len sh   n     i      q      ei      eq   es
    vecs[0] = '{      4,  0,   4,   100,   -50,    400,   -200, 0};
    vecs[1] = '{    127,  0, 127,  2047, -2048,  32767, -32768, 1};
    vecs[3] = '{      0,  0,   1,     5,    -7,      5,     -7, 0};
    vecs[4] = '{     16,  7,  16,   100,  -100,    100,   -100, 0};
    vecs[5] = '{     20,  1,  20,  2047,  2047,  20470,  20470, 0};
    vecs[6] = '{     10,  3,  10, -2048,  1000,  -2560,   1250, 0};
    vecs[7] = '{     33,  0,  33,  1000, -1000,  32767, -32768, 1};
    vecs[8] = '{     16,  0,  16,  2047, -2048,  32752, -32768, 0};
`ifdef COH_ACC_ROUND_EN
    vecs[2] = '{      3,  2,   3,     1,    -1,      1,     -1, 0};
    vecs[9] = '{      1,  4,   1,    -1,   -17,      0,     -1, 0};
`else
    vecs[2] = '{      3,  2,   3,     1,    -1,      0,     -1, 0};
    vecs[9] = '{      1,  4,   1,    -1,   -17,     -1,     -2, 0};
`endif
    exp_c = '{10, 35, 60, 85};

    rst_b    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    cont     = 1'b0;
    acc_len  = 7'd0;
    shift    = 3'd0;
    in_valid = 1'b0;
    in_i     = '0;
    in_q     = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_i", int'($signed(out_i)), 0);
    chk("rst_out_q", int'($signed(out_q)), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sat_flag", int'(sat_flag), 0);
    chk("rst_state", int'(fsm_state), 0);
    rst_b = 1'b1;
    @(negedge clk);

    // Table-driven windows
    for (int t = 0; t < 10; t++) run_window(t, vecs[t]);

    // Continuous mode: len 5, samples 0..19 back to back, cont dropped on the last one
    @(negedge clk);
    start = 1'b1; acc_len = 7'd5; shift = 3'd0; cont = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1;
      in_i     = 12'(k);
      in_q     = 12'(-k);
      if (k == 19) cont = 1'b0;
      @(negedge clk);
      if (out_valid) pulses++;
      if (k % 5 == 4) begin
        chk($sformatf("cont_valid_%0d", k), int'(out_valid), 1);
        chk($sformatf("cont_out_i_%0d", k), int'($signed(out_i)), exp_c[k / 5]);
      end
      if (k == 12) chk("cont_busy_mid", int'(busy), 1);
    end
    in_valid = 1'b0;
    chk("cont_pulse_count", pulses, 4);
    chk("cont_out_q_last", int'($signed(out_q)), -85);
    chk("cont_busy_end", int'(busy), 0);

    // Abort on the 8th sample with gaps; a start in the middle must be ignored
    @(negedge clk);
    start = 1'b1; acc_len = 7'd8; shift = 3'd0;
    @(negedge clk);
    start = 1'b0;
    ov_seen = 0;
    for (int s = 0; s < 8; s++) begin
      in_valid = 1'b1;
      in_i     = 12'sd7;
      in_q     = 12'sd1;
      if (s == 7) abort = 1'b1;
      @(negedge clk);
      if (out_valid) ov_seen++;
      in_valid = 1'b0;
      abort    = 1'b0;
      if (s < 7) begin
        if (s == 3) begin
          start   = 1'b1;
          acc_len = 7'd3;
        end
        @(negedge clk);
        start = 1'b0;
        if (out_valid) ov_seen++;
      end
    end
    chk("abort_busy_next", int'(busy), 0);
    @(negedge clk);
    if (out_valid) ov_seen++;
    chk("abort_no_valid", ov_seen, 0);
    chk("abort_out_i_held", int'($signed(out_i)), 85);
    chk("abort_out_q_held", int'($signed(out_q)), -85);
    v2 = '{2, 0, 2, 7, -3, 14, -6, 0};
    run_window(20, v2);

    // sat_flag survives an abort in IDLE
    run_window(21, vecs[7]);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_sat_held", int'(sat_flag), 1);
    chk("abort_idle_busy", int'(busy), 0);

    // Asynchronous reset mid-window after 3 of 6 samples
    @(negedge clk);
    start = 1'b1; acc_len = 7'd6; shift = 3'd0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_i     = 12'sd50;
      in_q     = -12'sd50;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2 rst_b = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out_i", int'($signed(out_i)), 0);
    chk("arst_out_q", int'($signed(out_q)), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_sat_flag", int'(sat_flag), 0);
    @(negedge clk);
    rst_b = 1'b1;
    ov_seen = 0;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_i     = 12'sd9;
      in_q     = 12'sd9;
      @(negedge clk);
      if (out_valid) ov_seen++;
    end
    in_valid = 1'b0;
    chk("post_rst_no_valid", ov_seen, 0);
    chk("post_rst_busy", int'(busy), 0);
    run_window(30, vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
